// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and default width.
package serial_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_sub.sv
// 1-bit full subtractor cell: dif = a - b - bin, bor = borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic dif,
  output logic bor
);

  assign dif = a ^ b ^ bin;
  assign bor = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: computes a - b - bin one bit per cycle, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              borrow;
  logic              bit_dif;
  logic              bit_bor;

  full_sub u_cell (
    .a   (a_q[cnt]),
    .b   (b_q[cnt]),
    .bin (borrow),
    .dif (bit_dif),
    .bor (bit_bor)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Results are only written during RUN, so they hold through DONE and IDLE until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      borrow <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          diff[cnt] <= bit_dif;
          borrow    <= bit_bor;
          if (cnt == LAST) begin
            bout  <= bit_bor;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (bit_dif != a_q[WIDTH-1]);
`endif
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8); ovf checks active when SERIAL_SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    int               cycle;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation, on time and one cycle wide.
  always @(negedge clk) begin
    if (!rst && done) begin
      checkOutput("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("latency", cyc, e.cycle);
        checkOutput("diff", {24'd0, diff}, {24'd0, e.diff});
        checkOutput("bout", {31'd0, bout}, {31'd0, e.bout});
`ifdef SERIAL_SUB_OVF_EN
        checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
      end
    end
    prev_done = done && !rst;
  end

  // Called at a negedge; the start is sampled at the following posedge.
  task automatic applyStimulus(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                               input logic tbin, input logic [WIDTH-1:0] ed,
                               input logic eb, input logic eo);
    exp_t e;
    a = ta; b = tb; bin = tbin; start = 1'b1;
    e.diff = ed; e.bout = eb; e.ovf = eo; e.cycle = cyc + 1 + WIDTH;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_diff", {24'd0, diff}, 32'd0);
    checkOutput("rst_bout", {31'd0, bout}, 32'd0);
    repeat (2) @(negedge clk);

    // Start driven in the same cycle reset drops must be accepted on the first edge.
    rst = 1'b0;
    applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    drain();
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);
    checkOutput("hold_diff", {24'd0, diff}, 32'h02);

    applyStimulus(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    drain();
    applyStimulus(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    drain();
    applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    drain();
    applyStimulus(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    drain();

    // A second start during RUN must be ignored.
    applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h11; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (12) @(negedge clk);
    checkOutput("ignored_busy", {31'd0, busy}, 32'd0);
    checkOutput("ignored_diff", {24'd0, diff}, 32'h02);

    // Asynchronous reset in the middle of RUN.
    a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, done}, 32'd0);
    checkOutput("midrst_diff", {24'd0, diff}, 32'd0);
    checkOutput("midrst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    checkOutput("midrst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("after_rst_busy", {31'd0, busy}, 32'd0);
    applyStimulus(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    drain();

    // Start held high: accepted every WIDTH+2 cycles.
    begin
      exp_t e;
      int base;
      base = cyc + 1;
      a = 8'h09; b = 8'h04; bin = 1'b0; start = 1'b1;
      for (int i = 0; i < 3; i++) begin
        e.diff = 8'h05; e.bout = 1'b0; e.ovf = 1'b0;
        e.cycle = base + i * (WIDTH + 2) + WIDTH;
        sb.push_back(e);
      end
      repeat (21) @(negedge clk);
      start = 1'b0;
      drain();
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port: a  input  WIDTH  minuend, captured on an accepted start.
REQ-006 SHALL have port: b  input  WIDTH  subtrahend, captured on an accepted start.
REQ-007 SHALL have port: bin  input  1  initial borrow-in, captured on an accepted start.
REQ-008 SHALL have port: busy  output  1  high in RUN and DONE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port: diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
REQ-011 SHALL have port: bout  output  1  final borrow-out (1 when a < b + bin, unsigned).
REQ-012 SHALL have port: ovf  output  1  signed overflow; present only when SERIAL_SUB_OVF_EN is defined.

Function
REQ-013 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE: capture a, b and bin; clear the bit counter; go to RUN.
REQ-015 SHALL ignore start in RUN or DONE, without queuing it and without disturbing the operation in progress.
REQ-016 SHALL, in RUN, process one bit per cycle, LSB first, through a single 1-bit full-subtractor cell.
REQ-017 SHALL feed the cell with operand bit i and the registered borrow; it SHALL write the difference bit to diff[i] and update the registered borrow.
REQ-018 SHALL take exactly WIDTH cycles in RUN; after the bit WIDTH-1 cycle, it SHALL go to DONE.
REQ-019 SHALL, in DONE, assert done for exactly one cycle, present the final borrow on bout, then return to IDLE.
REQ-020 SHALL have a latency of WIDTH+1 cycles: start accepted at edge k -> done high during the cycle after edge k+WIDTH.
REQ-021 SHALL hold diff, bout and ovf stable from DONE until the next accepted start.
REQ-022 SHALL update diff bits progressively while in RUN; diff is valid only when done is high or in IDLE after a completed operation.
REQ-023 SHALL size the bit counter to $clog2(WIDTH) bits with no wrap beyond WIDTH-1.
REQ-024 SHALL accept a start asserted in the first IDLE cycle after DONE, giving back-to-back operations with a WIDTH+2 cycle period.

Reset
REQ-025 SHALL, while rst is high, immediately force state=IDLE, busy=0, done=0, diff=0, bout=0, ovf=0, counter=0 and borrow=0.
REQ-026 SHALL, on a reset in the middle of RUN, abandon the operation; no done pulse SHALL follow.
REQ-027 SHALL accept a start on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, when SERIAL_SUB_OVF_EN is defined, include the ovf port.
REQ-029 SHALL, when SERIAL_SUB_OVF_EN is defined, set ovf in DONE to (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-030 SHALL, when SERIAL_SUB_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take the FSM state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2) from the shared package serial_sub_pkg.
REQ-032 SHALL take the default-WIDTH constant from serial_sub_pkg.
REQ-033 SHALL instantiate the existing full_sub cell (inputs a, b, bin; outputs dif, bor) once as its sole sub-module.
REQ-034 SHALL NOT duplicate the full_sub bit equations inline.

Verification (WIDTH=8)
REQ-035 SHALL cover: a=0x05, b=0x03, bin=0 -> done at cycle 9 after start; diff=0x02, bout=0, ovf=0.
REQ-036 SHALL cover: a=0x03, b=0x05, bin=0 -> diff=0xFE, bout=1, ovf=0.
REQ-037 SHALL cover: a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1; and a=0x80, b=0x01 -> diff=0x7F, ovf=1 (macro defined).
REQ-038 SHALL cover: start pulsed again 3 cycles after an accepted start with different operands -> ignored; the first result is unchanged and exactly one done pulse occurs.
REQ-039 SHALL cover: rst asserted 4 cycles into RUN -> all outputs 0 immediately; no done pulse; a subsequent start of 0x10-0x01 gives diff=0x0F.
REQ-040 SHALL cover: start held high continuously -> operations repeat every 10 cycles; done pulses each exactly 1 cycle wide.
